multdiv_issue: RTL and testbench

- Pipeline-side initiator for the multdiv unit, sitting between the execute stage and the multdiv block.
- Detects a MUL/DIV instruction and latches its operands and destination register.
- Fires a one-cycle ctrl_MULT or ctrl_DIV pulse, then holds the pipeline stalled until data_resultRDY.
- Delivers the result, or the exception status, as a single writeback.

---
 rtl/multdiv_issue_pkg.sv | 29 ++
 rtl/md_reg.sv | 25 ++
 rtl/md_wait_counter.sv | 35 +++
 rtl/multdiv_issue.sv | 173 +++++++++++++++++
 tb/tb_multdiv_issue.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/multdiv_issue_pkg.sv
// Shared definitions for the multdiv issue path: FSM state encoding, exception
// register/codes and the writeback record, also used by execute-stage exception logic.
package multdiv_issue_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_WB    = 3'd3,
        S_DRAIN = 3'd4
    } md_state_e;

    localparam logic [4:0]  DEF_RSTATUS_REG   = 5'd30;
    localparam logic [31:0] DEF_MULT_EXC_CODE = 32'd4;
    localparam logic [31:0] DEF_DIV_EXC_CODE  = 32'd5;
    localparam int unsigned DEF_TIMEOUT       = 64;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_t;

    function automatic logic [31:0] exc_code(input logic        is_div,
                                             input logic [31:0] mult_code,
                                             input logic [31:0] div_code);
        return is_div ? div_code : mult_code;
    endfunction

endpackage

// File: rtl/md_reg.sv
// Generic enabled register with synchronous active-high clear to zero.
module md_reg #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] q_q;

    // NOTE: every register here is reset because the block's outputs must read zero after reset.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            q_q <= '0;
        end else if (en_i) begin
            q_q <= d_i;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/md_wait_counter.sv
// WAIT/DRAIN cycle counter: clear, count enable, and a terminal-count flag at TIMEOUT-1.
module md_wait_counter #(
    parameter int unsigned TIMEOUT = 64,
    localparam int unsigned CW     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1
) (
    input  logic clock_i,
    input  logic reset_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic tc_o
);

    logic [CW-1:0] count_q, count_d;

    // Saturates at terminal count so a stuck enable can never wrap back to zero.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i && !tc_o) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc_o = (count_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/multdiv_issue.sv
// Execute-side initiator for the multdiv unit: latches a MUL/DIV, pulses the start
// strobe, stalls the pipeline until the result returns, and emits one writeback.
module multdiv_issue
    import multdiv_issue_pkg::*;
#(
    parameter logic [4:0]  RSTATUS_REG   = DEF_RSTATUS_REG,
    parameter logic [31:0] MULT_EXC_CODE = DEF_MULT_EXC_CODE,
    parameter logic [31:0] DIV_EXC_CODE  = DEF_DIV_EXC_CODE,
    parameter int unsigned TIMEOUT       = DEF_TIMEOUT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        insn_valid,
    input  logic        is_mult,
    input  logic        is_div,
    input  logic        flush,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic [4:0]  rd,
    output logic        ctrl_MULT,
    output logic        ctrl_DIV,
    output logic [31:0] data_operandA,
    output logic [31:0] data_operandB,
    input  logic [31:0] data_result,
    input  logic        data_exception,
    input  logic        data_resultRDY,
    output logic        stall,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        timeout_err
);

    md_state_e   state_q, state_d;
    logic        accept;
    logic        ctrl_mult_q, ctrl_mult_d;
    logic        ctrl_div_q, ctrl_div_d;
    logic        wb_valid_q, wb_valid_d;
    logic        timeout_err_q, timeout_err_d;
    logic        op_is_div_q;
    logic [4:0]  rd_q;
    logic        wb_load;
    wb_t         wb_d, wb_q;
    wb_t         exc_wb;
    logic        cnt_clear, cnt_enable, cnt_tc;

    assign exc_wb = '{rd: RSTATUS_REG,
                      data: exc_code(op_is_div_q, MULT_EXC_CODE, DIV_EXC_CODE)};

    // NOTE: all next-state signals get a default first so no path through the case infers a latch.
    always_comb begin
        accept        = (state_q == S_IDLE) & insn_valid & (is_mult | is_div) & ~flush;
        state_d       = state_q;
        ctrl_mult_d   = 1'b0;
        ctrl_div_d    = 1'b0;
        wb_valid_d    = 1'b0;
        timeout_err_d = timeout_err_q;
        wb_load       = 1'b0;
        wb_d          = '{rd: rd_q, data: data_result};
        cnt_clear     = 1'b0;
        cnt_enable    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d     = S_ISSUE;
                    ctrl_div_d  = is_div;
                    ctrl_mult_d = ~is_div;
                end
            end
            S_ISSUE: begin
                // A ready left over from the previous operation is deliberately ignored here.
                cnt_clear = 1'b1;
                state_d   = flush ? S_DRAIN : S_WAIT;
            end
            S_WAIT: begin
                cnt_enable = 1'b1;
                if (flush) begin
                    if (data_resultRDY) begin
                        state_d = S_IDLE;
                    end else if (cnt_tc) begin
                        state_d       = S_IDLE;
                        timeout_err_d = 1'b1;
                    end else begin
                        state_d = S_DRAIN;
                    end
                end else if (data_resultRDY) begin
                    state_d    = S_WB;
                    wb_valid_d = 1'b1;
                    wb_load    = 1'b1;
                    if (data_exception) begin
                        wb_d = exc_wb;
                    end
                end else if (cnt_tc) begin
                    state_d       = S_WB;
                    wb_valid_d    = 1'b1;
                    wb_load       = 1'b1;
                    timeout_err_d = 1'b1;
                    wb_d          = exc_wb;
                end
            end
            S_WB: begin
                state_d = S_IDLE;
            end
            S_DRAIN: begin
                cnt_enable = 1'b1;
                if (data_resultRDY) begin
                    state_d = S_IDLE;
                end else if (cnt_tc) begin
                    state_d       = S_IDLE;
                    timeout_err_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= S_IDLE;
            ctrl_mult_q   <= 1'b0;
            ctrl_div_q    <= 1'b0;
            wb_valid_q    <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            ctrl_mult_q   <= ctrl_mult_d;
            ctrl_div_q    <= ctrl_div_d;
            wb_valid_q    <= wb_valid_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    md_reg #(.WIDTH(32)) u_opa_reg (
        .clock_i (clock), .reset_i (reset), .en_i (accept), .d_i (op_a), .q_o (data_operandA)
    );

    md_reg #(.WIDTH(32)) u_opb_reg (
        .clock_i (clock), .reset_i (reset), .en_i (accept), .d_i (op_b), .q_o (data_operandB)
    );

    md_reg #(.WIDTH(5)) u_rd_reg (
        .clock_i (clock), .reset_i (reset), .en_i (accept), .d_i (rd), .q_o (rd_q)
    );

    md_reg #(.WIDTH(1)) u_isdiv_reg (
        .clock_i (clock), .reset_i (reset), .en_i (accept), .d_i (is_div), .q_o (op_is_div_q)
    );

    md_reg #(.WIDTH($bits(wb_t))) u_wb_reg (
        .clock_i (clock), .reset_i (reset), .en_i (wb_load), .d_i (wb_d), .q_o (wb_q)
    );

    md_wait_counter #(.TIMEOUT(TIMEOUT)) u_wait_counter (
        .clock_i  (clock),
        .reset_i  (reset),
        .clear_i  (cnt_clear),
        .enable_i (cnt_enable),
        .tc_o     (cnt_tc)
    );

    assign stall       = accept | (state_q == S_ISSUE) | (state_q == S_WAIT) | (state_q == S_DRAIN);
    assign ctrl_MULT   = ctrl_mult_q;
    assign ctrl_DIV    = ctrl_div_q;
    assign wb_valid    = wb_valid_q;
    assign wb_rd       = wb_q.rd;
    assign wb_data     = wb_q.data;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_multdiv_issue.sv
// Self-checking bench for multdiv_issue: vector table plus hand-written corner sequences,
// with a writeback scoreboard checked by a negedge monitor.
module tb_multdiv_issue;

    logic        clock = 1'b0;
    logic        reset;
    logic        insn_valid, is_mult, is_div, flush;
    logic [31:0] op_a, op_b;
    logic [4:0]  rd;
    logic        ctrl_MULT, ctrl_DIV;
    logic [31:0] data_operandA, data_operandB;
    logic [31:0] data_result;
    logic        data_exception, data_resultRDY;
    logic        stall, wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        timeout_err;

    multdiv_issue dut (
        .clock          (clock),
        .reset          (reset),
        .insn_valid     (insn_valid),
        .is_mult        (is_mult),
        .is_div         (is_div),
        .flush          (flush),
        .op_a           (op_a),
        .op_b           (op_b),
        .rd             (rd),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .stall          (stall),
        .wb_valid       (wb_valid),
        .wb_rd          (wb_rd),
        .wb_data        (wb_data),
        .timeout_err    (timeout_err)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } exp_wb_t;

    typedef struct {
        logic        m;
        logic        d;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        int          dly;
        logic        exc;
        logic [31:0] res;
        logic [4:0]  exp_rd;
        logic [31:0] exp_data;
    } vec_t;

    exp_wb_t sb_q[$];
    vec_t    vecs[6];
    int      n_checks = 0;
    int      n_fail   = 0;
    int      n_mult   = 0;
    int      n_div    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        insn_valid = 1'b0;
        is_mult    = 1'b0;
        is_div     = 1'b0;
    endtask

    // Writeback monitor and start-pulse counters.
    always @(negedge clock) begin
        if (ctrl_MULT) n_mult++;
        if (ctrl_DIV)  n_div++;
        if (wb_valid) begin
            if (sb_q.size() == 0) begin
                check("wb_unexpected", {31'd0, wb_valid}, 32'd0);
            end else begin
                exp_wb_t e;
                e = sb_q.pop_front();
                check("wb_rd", {27'd0, wb_rd}, {27'd0, e.rd});
                check("wb_data", wb_data, e.data);
            end
        end
    end

    // Runs one op with a multdiv model that answers dly cycles after the start pulse.
    task automatic run_op(input int idx, input vec_t v);
        int m0, d0;
        m0 = n_mult;
        d0 = n_div;
        sb_q.push_back('{rd: v.exp_rd, data: v.exp_data});
        insn_valid = 1'b1; is_mult = v.m; is_div = v.d;
        op_a = v.a; op_b = v.b; rd = v.rd;
        #1 check($sformatf("v%0d_stall_accept", idx), {31'd0, stall}, 32'd1);
        step();
        idle_inputs();
        op_a = ~v.a; op_b = ~v.b; rd = ~v.rd;
        check($sformatf("v%0d_ctrl_div", idx), {31'd0, ctrl_DIV}, {31'd0, v.d});
        check($sformatf("v%0d_ctrl_mult", idx), {31'd0, ctrl_MULT}, {31'd0, v.m & ~v.d});
        check($sformatf("v%0d_opA", idx), data_operandA, v.a);
        for (int i = 0; i < v.dly; i++) begin
            step();
            check($sformatf("v%0d_stall_wait", idx), {31'd0, stall}, 32'd1);
        end
        data_resultRDY = 1'b1; data_result = v.res; data_exception = v.exc;
        step();
        data_resultRDY = 1'b0; data_exception = 1'b0; data_result = 32'h0BAD_0BAD;
        check($sformatf("v%0d_wb_valid", idx), {31'd0, wb_valid}, 32'd1);
        check($sformatf("v%0d_stall_wb", idx), {31'd0, stall}, 32'd0);
        check($sformatf("v%0d_opB_stable", idx), data_operandB, v.b);
        step();
        check($sformatf("v%0d_wb_once", idx), {31'd0, wb_valid}, 32'd0);
        check($sformatf("v%0d_mult_pulses", idx), 32'(n_mult - m0), {31'd0, v.m & ~v.d});
        check($sformatf("v%0d_div_pulses", idx), 32'(n_div - d0), {31'd0, v.d});
        check($sformatf("v%0d_sb_drained", idx), 32'(sb_q.size()), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        vecs[0] = '{1'b1, 1'b0, 32'd7,        32'd6,        5'd5,  16, 1'b0, 32'd42,         5'd5,  32'd42};
        vecs[1] = '{1'b0, 1'b1, 32'd10,       32'd0,        5'd9,  3,  1'b1, 32'hDEAD_BEEF,  5'd30, 32'd5};
        vecs[2] = '{1'b1, 1'b1, 32'd100,      32'd7,        5'd4,  2,  1'b0, 32'd14,         5'd4,  32'd14};
        vecs[3] = '{1'b1, 1'b0, 32'h0000_FFFF, 32'h0001_0001, 5'd31, 1, 1'b0, 32'hFFFF_FFFF, 5'd31, 32'hFFFF_FFFF};
        vecs[4] = '{1'b1, 1'b0, 32'h4000_0000, 32'd8,       5'd2,  4,  1'b1, 32'h1234_5678,  5'd30, 32'd4};
        vecs[5] = '{1'b0, 1'b1, 32'd1000,     32'd10,       5'd12, 7,  1'b0, 32'd100,        5'd12, 32'd100};

        reset = 1'b1; flush = 1'b0; idle_inputs();
        op_a = '0; op_b = '0; rd = '0;
        data_result = '0; data_exception = 1'b0; data_resultRDY = 1'b0;
        step();
        step();
        check("rst_ctrl", {30'd0, ctrl_MULT, ctrl_DIV}, 32'd0);
        check("rst_wb", {31'd0, wb_valid} | {27'd0, wb_rd} | wb_data, 32'd0);
        check("rst_ops", data_operandA | data_operandB, 32'd0);
        check("rst_flags", {30'd0, stall, timeout_err}, 32'd0);
        reset = 1'b0;
        step();

        for (int i = 0; i < 6; i++) run_op(i, vecs[i]);

        // Stale ready held through ISSUE must not be taken as the result.
        data_resultRDY = 1'b1; data_result = 32'd777;
        sb_q.push_back('{rd: 5'd3, data: 32'd99});
        insn_valid = 1'b1; is_mult = 1'b1; op_a = 32'd9; op_b = 32'd11; rd = 5'd3;
        step();
        idle_inputs();
        check("stale_ctrl_mult", {31'd0, ctrl_MULT}, 32'd1);
        step();
        data_resultRDY = 1'b0; data_result = 32'd0;
        check("stale_no_early_wb", {31'd0, wb_valid}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            step();
            check("stale_wait_stall", {31'd0, stall | wb_valid}, 32'd1);
        end
        data_resultRDY = 1'b1; data_result = 32'd99;
        step();
        data_resultRDY = 1'b0;
        check("stale_wb_valid", {31'd0, wb_valid}, 32'd1);
        step();

        // Flush three cycles into WAIT: drain until ready, no writeback.
        insn_valid = 1'b1; is_mult = 1'b1; op_a = 32'd50; op_b = 32'd5; rd = 5'd6;
        step();
        idle_inputs();
        repeat (3) step();
        step();
        flush = 1'b1;
        #1 check("flush_stall_wait", {31'd0, stall}, 32'd1);
        step();
        flush = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("flush_stall_drain", {31'd0, stall}, 32'd1);
            step();
        end
        data_resultRDY = 1'b1; data_result = 32'd250;
        step();
        data_resultRDY = 1'b0;
        check("flush_idle_stall", {31'd0, stall}, 32'd0);
        check("flush_no_wb", {31'd0, wb_valid}, 32'd0);
        run_op(6, '{1'b1, 1'b0, 32'd3, 32'd3, 5'd7, 2, 1'b0, 32'd9, 5'd7, 32'd9});

        // Flush in IDLE blocks accept.
        insn_valid = 1'b1; is_mult = 1'b1; flush = 1'b1; op_a = 32'd1; op_b = 32'd1; rd = 5'd1;
        #1 check("idle_flush_no_stall", {31'd0, stall}, 32'd0);
        step();
        idle_inputs(); flush = 1'b0;
        check("idle_flush_no_ctrl", {30'd0, ctrl_MULT, ctrl_DIV}, 32'd0);
        step();

        // Timeout: ready never arrives.
        sb_q.push_back('{rd: 5'd30, data: 32'd4});
        insn_valid = 1'b1; is_mult = 1'b1; op_a = 32'd21; op_b = 32'd2; rd = 5'd11;
        step();
        idle_inputs();
        check("to_err_before", {31'd0, timeout_err}, 32'd0);
        n = 0;
        while (!wb_valid && n < 200) begin
            step();
            n++;
        end
        check("to_latency", 32'(n), 32'd65);
        check("to_err_set", {31'd0, timeout_err}, 32'd1);
        step();
        check("to_err_sticky", {31'd0, timeout_err}, 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("to_err_reset", {31'd0, timeout_err}, 32'd0);
        step();

        // Reset during WAIT discards the op; a late ready must not write back.
        run_op(7, '{1'b1, 1'b0, 32'd5, 32'd5, 5'd13, 1, 1'b0, 32'd25, 5'd13, 32'd25});
        insn_valid = 1'b1; is_mult = 1'b1; op_a = 32'd13; op_b = 32'd17; rd = 5'd8;
        step();
        idle_inputs();
        repeat (3) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("mrst_ctrl", {30'd0, ctrl_MULT, ctrl_DIV}, 32'd0);
        check("mrst_ops", data_operandA | data_operandB, 32'd0);
        check("mrst_wb", {31'd0, wb_valid} | {27'd0, wb_rd} | wb_data, 32'd0);
        check("mrst_flags", {30'd0, stall, timeout_err}, 32'd0);
        data_resultRDY = 1'b1; data_result = 32'd221;
        step();
        data_resultRDY = 1'b0;
        step();
        check("mrst_no_wb", {31'd0, wb_valid}, 32'd0);

        // Back-to-back: the second accept lands in the cycle after the first WB.
        run_op(8, '{1'b1, 1'b0, 32'd2, 32'd3, 5'd1, 1, 1'b0, 32'd6,  5'd1, 32'd6});
        run_op(9, '{1'b1, 1'b0, 32'd4, 32'd5, 5'd2, 1, 1'b0, 32'd20, 5'd2, 32'd20});

        step();
        check("final_sb_empty", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
